// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encodings, tag prefix and the bit-period default shared with uart_tx.
package uart_tx_arbiter_pkg;

    localparam int unsigned GRANT_W      = 3;
    localparam logic [3:0]  TAG_PREFIX   = 4'hF;
    localparam int unsigned CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        ARB_HOLD      = 3'd0,
        ARB_IDLE      = 3'd1,
        ARB_ISSUE     = 3'd2,
        ARB_WAIT      = 3'd3,
        ARB_TAG_ISSUE = 3'd4,
        ARB_TAG_WAIT  = 3'd5
    } arb_state_e;

    function automatic logic [7:0] tag_byte(input logic [GRANT_W-1:0] id);
        return {TAG_PREFIX, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer and transmitter handshake bundle for uart_tx_arbiter.
// Signal names and directions are as seen from the arbiter (master modport).
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   i_Req;
    logic [8*N_REQ-1:0] i_Req_Byte;
    logic [N_REQ-1:0]   o_Ack;
    logic               o_Tx_DV;
    logic [7:0]         o_Tx_Byte;
    logic               i_Tx_Done;
    logic               o_Busy;
    logic [2:0]         o_Grant_Id;

    modport master (
        input  i_Req, i_Req_Byte, i_Tx_Done,
        output o_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Grant_Id
    );

    modport slave (
        output i_Req, i_Req_Byte, i_Tx_Done,
        input  o_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Grant_Id
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// i_Start with wrap-around.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]   i_Req,
    input  logic [GRANT_W-1:0] i_Start,
    output logic [GRANT_W-1:0] o_Winner,
    output logic               o_Valid
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    // Rotate so that bit 0 of w_rot is requester i_Start.
    assign w_dbl = {i_Req, i_Req};
    assign w_rot = N_REQ'(w_dbl >> i_Start);

    always_comb begin
        o_Valid  = 1'b0;
        o_Winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_Valid && w_rot[i]) begin
                o_Valid  = 1'b1;
                o_Winner = GRANT_W'((int'(i_Start) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Define UART_TX_ARB_TAG_EN to precede each data byte with tag byte 8'hF0 | id.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned HOLDOFF_CLKS = 20,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    uart_tx_arbiter_if.master io_Bus
);

    localparam logic [GRANT_W-1:0] LAST_ID = GRANT_W'(N_REQ - 1);

    arb_state_e         r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [N_REQ-1:0]   r_ack,      w_ack_nxt;
    logic               r_tx_dv,    w_tx_dv_nxt;
    logic [7:0]         r_tx_byte,  w_tx_byte_nxt;
    logic               r_busy,     w_busy_nxt;
    logic [GRANT_W-1:0] r_grant_id, w_grant_id_nxt;

    logic [GRANT_W-1:0] w_start;
    logic [GRANT_W-1:0] w_pick_id;
    logic               w_pick_valid;
    logic [GRANT_W-1:0] w_sel_id;
    logic [7:0]         w_sel_byte;
    logic [N_REQ-1:0]   w_sel_onehot;

    // Priority starts one past the last grant.
    assign w_start = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_Req    (io_Bus.i_Req),
        .i_Start  (w_start),
        .o_Winner (w_pick_id),
        .o_Valid  (w_pick_valid)
    );

    // Data byte is taken from the new winner, or from the held grant when a tag frame goes first.
`ifdef UART_TX_ARB_TAG_EN
    assign w_sel_id = r_grant_id;
`else
    assign w_sel_id = w_pick_id;
`endif

    always_comb begin
        w_sel_byte   = '0;
        w_sel_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel_id == GRANT_W'(k)) begin
                w_sel_byte      = io_Bus.i_Req_Byte[8*k +: 8];
                w_sel_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ack_nxt      = '0;
        w_tx_dv_nxt    = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_busy_nxt     = r_busy;
        w_grant_id_nxt = r_grant_id;
        case (r_state)
            ARB_HOLD: begin
                if (r_cnt >= CNT_W'(HOLDOFF_CLKS - 1)) begin
                    w_state_nxt = ARB_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_id_nxt = w_pick_id;
                    w_busy_nxt     = 1'b1;
                    w_tx_dv_nxt    = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                    w_tx_byte_nxt  = tag_byte(w_pick_id);
                    w_state_nxt    = ARB_TAG_ISSUE;
`else
                    w_tx_byte_nxt  = w_sel_byte;
                    w_ack_nxt      = w_sel_onehot;
                    w_state_nxt    = ARB_ISSUE;
`endif
                end
            end
            ARB_ISSUE: w_state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                if (io_Bus.i_Tx_Done) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ARB_IDLE;
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            ARB_TAG_ISSUE: w_state_nxt = ARB_TAG_WAIT;
            ARB_TAG_WAIT: begin
                if (io_Bus.i_Tx_Done) begin
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_byte_nxt = w_sel_byte;
                    w_ack_nxt     = w_sel_onehot;
                    w_state_nxt   = ARB_ISSUE;
                end
            end
`endif
            default: w_state_nxt = ARB_HOLD;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state    <= ARB_HOLD;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= LAST_ID;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_tx_dv    <= w_tx_dv_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_busy     <= w_busy_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    assign io_Bus.o_Ack      = r_ack;
    assign io_Bus.o_Tx_DV    = r_tx_dv;
    assign io_Bus.o_Tx_Byte  = r_tx_byte;
    assign io_Bus.o_Busy     = r_busy;
    assign io_Bus.o_Grant_Id = r_grant_id;

endmodule
